// File: rtl/rsa_roundtrip_seq.sv
// Round-trip RSA sequencer: drives the Montgomery exponentiation engine through a
// four-phase go/done handshake to encrypt a message with the public key, decrypt
// the ciphertext with the private key, and report whether the plaintext came back.
module rsa_roundtrip_seq #(
   parameter int unsigned BITS           = 128,
   parameter int unsigned TIMEOUT_CYCLES = 1 << 24
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            abort,
   input  logic [BITS-1:0] msg,
   input  logic [BITS-1:0] pub_exp,
   input  logic [BITS-1:0] priv_exp,
   input  logic [BITS-1:0] modulus,
   output logic [BITS-1:0] eng_x,
   output logic [BITS-1:0] eng_e,
   output logic [BITS-1:0] eng_m,
   output logic            eng_go,
   input  logic            eng_done,
   input  logic [BITS-1:0] eng_z,
   output logic [BITS-1:0] cipher,
   output logic [BITS-1:0] plain,
   output logic            busy,
   output logic            pass,
   output logic            fail,
   output logic            timeout,
   output logic            err_operand,
   output logic [2:0]      state
);

   localparam int unsigned WdogW = 25;
   localparam logic [WdogW-1:0] WdogMax = WdogW'(TIMEOUT_CYCLES - 32'd1);

   // Encodings are visible on the LEDs, so they are pinned explicitly.
   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StSync   = 3'd1,
      StEncGo  = 3'd2,
      StEncRel = 3'd3,
      StDecGo  = 3'd4,
      StDecRel = 3'd5,
      StCheck  = 3'd6
   } state_e;

   state_e           state_q, state_d;
   logic [WdogW-1:0] wdog_q, wdog_d;
   logic             start_q, start_d;
   logic [BITS-1:0]  msg_q, msg_d;
   logic [BITS-1:0]  pub_exp_q, pub_exp_d;
   logic [BITS-1:0]  priv_exp_q, priv_exp_d;
   logic [BITS-1:0]  modulus_q, modulus_d;
   logic [BITS-1:0]  eng_x_q, eng_x_d;
   logic [BITS-1:0]  eng_e_q, eng_e_d;
   logic [BITS-1:0]  eng_m_q, eng_m_d;
   logic             eng_go_q, eng_go_d;
   logic [BITS-1:0]  cipher_q, cipher_d;
   logic [BITS-1:0]  plain_q, plain_d;
   logic             busy_q, busy_d;
   logic             pass_q, pass_d;
   logic             fail_q, fail_d;
   logic             timeout_q, timeout_d;
   logic             err_operand_q, err_operand_d;

   logic accept;
   logic bad_operand;
   logic wdog_tick;

   assign accept      = start && !start_q && (state_q == StIdle) && !abort;
   // Montgomery needs an odd modulus, and the message must be a residue of it.
   assign bad_operand = !modulus[0] || (msg >= modulus);

   // Next-state and registered-output logic; abort outranks every handshake event.
   always_comb begin
      state_d       = state_q;
      wdog_d        = wdog_q;
      start_d       = start;
      msg_d         = msg_q;
      pub_exp_d     = pub_exp_q;
      priv_exp_d    = priv_exp_q;
      modulus_d     = modulus_q;
      eng_x_d       = eng_x_q;
      eng_e_d       = eng_e_q;
      eng_m_d       = eng_m_q;
      eng_go_d      = eng_go_q;
      cipher_d      = cipher_q;
      plain_d       = plain_q;
      busy_d        = busy_q;
      pass_d        = pass_q;
      fail_d        = fail_q;
      timeout_d     = timeout_q;
      err_operand_d = err_operand_q;
      wdog_tick     = 1'b0;

      if (busy_q && abort) begin
         state_d       = StIdle;
         wdog_d        = '0;
         eng_go_d      = 1'b0;
         busy_d        = 1'b0;
         pass_d        = 1'b0;
         fail_d        = 1'b0;
         timeout_d     = 1'b0;
         err_operand_d = 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  msg_d         = msg;
                  pub_exp_d     = pub_exp;
                  priv_exp_d    = priv_exp;
                  modulus_d     = modulus;
                  pass_d        = 1'b0;
                  timeout_d     = 1'b0;
                  if (bad_operand) begin
                     err_operand_d = 1'b1;
                     fail_d        = 1'b1;
                     busy_d        = 1'b0;
                  end else begin
                     err_operand_d = 1'b0;
                     fail_d        = 1'b0;
                     busy_d        = 1'b1;
                     wdog_d        = '0;
                     state_d       = StSync;
                  end
               end
            end
            // Engine may still be holding done from an earlier exchange.
            StSync: begin
               if (!eng_done) begin
                  eng_go_d = 1'b1;
                  eng_x_d  = msg_q;
                  eng_e_d  = pub_exp_q;
                  eng_m_d  = modulus_q;
                  wdog_d   = '0;
                  state_d  = StEncGo;
               end else begin
                  wdog_tick = 1'b1;
               end
            end
            StEncGo: begin
               if (eng_done) begin
                  cipher_d = eng_z;
                  eng_go_d = 1'b0;
                  wdog_d   = '0;
                  state_d  = StEncRel;
               end else begin
                  wdog_tick = 1'b1;
               end
            end
            StEncRel: begin
               if (!eng_done) begin
                  eng_go_d = 1'b1;
                  eng_x_d  = cipher_q;
                  eng_e_d  = priv_exp_q;
                  wdog_d   = '0;
                  state_d  = StDecGo;
               end else begin
                  wdog_tick = 1'b1;
               end
            end
            StDecGo: begin
               if (eng_done) begin
                  plain_d  = eng_z;
                  eng_go_d = 1'b0;
                  wdog_d   = '0;
                  state_d  = StDecRel;
               end else begin
                  wdog_tick = 1'b1;
               end
            end
            StDecRel: begin
               if (!eng_done) begin
                  state_d = StCheck;
               end else begin
                  wdog_tick = 1'b1;
               end
            end
            StCheck: begin
               pass_d  = (plain_q == msg_q);
               fail_d  = (plain_q != msg_q);
               busy_d  = 1'b0;
               state_d = StIdle;
            end
            default: begin
               state_d = StIdle;
            end
         endcase

         // Watchdog only fires when the wait state made no progress this cycle.
         if (wdog_tick) begin
            if (wdog_q == WdogMax) begin
               eng_go_d  = 1'b0;
               timeout_d = 1'b1;
               fail_d    = 1'b1;
               busy_d    = 1'b0;
               wdog_d    = '0;
               state_d   = StIdle;
            end else begin
               wdog_d = wdog_q + 25'd1;
            end
         end
      end
   end

   // State and output registers; reset clears everything, dropping eng_go at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= StIdle;
         wdog_q        <= '0;
         start_q       <= 1'b0;
         msg_q         <= '0;
         pub_exp_q     <= '0;
         priv_exp_q    <= '0;
         modulus_q     <= '0;
         eng_x_q       <= '0;
         eng_e_q       <= '0;
         eng_m_q       <= '0;
         eng_go_q      <= 1'b0;
         cipher_q      <= '0;
         plain_q       <= '0;
         busy_q        <= 1'b0;
         pass_q        <= 1'b0;
         fail_q        <= 1'b0;
         timeout_q     <= 1'b0;
         err_operand_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         wdog_q        <= wdog_d;
         start_q       <= start_d;
         msg_q         <= msg_d;
         pub_exp_q     <= pub_exp_d;
         priv_exp_q    <= priv_exp_d;
         modulus_q     <= modulus_d;
         eng_x_q       <= eng_x_d;
         eng_e_q       <= eng_e_d;
         eng_m_q       <= eng_m_d;
         eng_go_q      <= eng_go_d;
         cipher_q      <= cipher_d;
         plain_q       <= plain_d;
         busy_q        <= busy_d;
         pass_q        <= pass_d;
         fail_q        <= fail_d;
         timeout_q     <= timeout_d;
         err_operand_q <= err_operand_d;
      end
   end

   assign eng_x       = eng_x_q;
   assign eng_e       = eng_e_q;
   assign eng_m       = eng_m_q;
   assign eng_go      = eng_go_q;
   assign cipher      = cipher_q;
   assign plain       = plain_q;
   assign busy        = busy_q;
   assign pass        = pass_q;
   assign fail        = fail_q;
   assign timeout     = timeout_q;
   assign err_operand = err_operand_q;
   assign state       = state_q;

endmodule

// File: doc/rsa_roundtrip_seq.md
# rsa_roundtrip_seq

Initiator side of the Montgomery exponentiation engine's go/done handshake. On a start request it encrypts a message with the public key, decrypts the ciphertext with the private key, and compares the recovered plaintext with the original, reporting pass/fail/timeout on LEDs and decimal points. It sits between the debounced button/switch logic and the exponentiation engine, in place of manual GO driving.

## Interface
Parameters:
- BITS, 128, operand/result width
- TIMEOUT_CYCLES, 2^24, watchdog limit per wait state; counter width is 25 bits

Ports:
- clk  in  1  system clock (sysclk)
- reset  in  1  asynchronous, active-high
- start  in  1  debounced level; rising edge requests a run
- abort  in  1  debounced level; synchronous abort while busy
- msg, pub_exp, priv_exp, modulus  in  BITS each  operands, sampled only on the accepted start edge
- eng_x, eng_e, eng_m  out  BITS each  engine operands (registered)
- eng_go  out  1  engine request (registered)
- eng_done  in  1  engine result valid
- eng_z  in  BITS  engine result
- cipher, plain  out  BITS each  captured encrypt/decrypt results
- busy, pass, fail, timeout, err_operand  out  1 each  status
- state  out  3  current state code for LEDs

## Operation
- States and codes: IDLE=0, SYNC=1, ENC_GO=2, ENC_REL=3, DEC_GO=4, DEC_REL=5, CHECK=6.
- Handshake is four-phase: raise eng_go with operands stable, hold until eng_done=1, capture eng_z, drop eng_go, wait for eng_done=0. Operands never change while eng_go=1.
- Start edge detection: start_q is registered; accept when start & ~start_q & IDLE & ~abort.
- IDLE, on accept: latch the operands into internal registers, clear pass/fail/timeout/err_operand, and set busy=1.
  - If modulus[0]==0 or msg>=modulus (unsigned BITS compare): set err_operand=1 and fail=1, drop busy, stay IDLE. The engine is never requested.
  - Otherwise go to SYNC.
- SYNC: wait for eng_done=0, then ENC_GO with eng_go=1, eng_x=msg, eng_e=pub_exp, eng_m=modulus, all updated on the same edge.
- ENC_GO: on eng_done=1, cipher<=eng_z and eng_go<=0, then go to ENC_REL.
- ENC_REL: on eng_done=0, go to DEC_GO with eng_go=1, eng_x=cipher, eng_e=priv_exp.
- DEC_GO: on eng_done=1, plain<=eng_z and eng_go<=0, then go to DEC_REL.
- DEC_REL: on eng_done=0, go to CHECK.
- CHECK: one cycle. pass<=(plain==msg latched), fail<=~pass, busy<=0, then IDLE.
- Flags hold until the next accepted start. cipher/plain hold until overwritten.
- Watchdog: the counter clears on entry to every state from SYNC to DEC_REL and increments each cycle while in them. At TIMEOUT_CYCLES-1: eng_go<=0, timeout=1, fail=1, busy=0, go to IDLE.
- Abort (busy and abort=1): eng_go<=0, all flags cleared, busy=0, go to IDLE. cipher/plain are unchanged.
- Priorities: reset > abort > eng_done > watchdog. Start while busy is ignored, with no queuing.
- eng_z is captured only in the ENC_GO/DEC_GO cycle where eng_done=1. eng_done pulses in other states are ignored except as level checks in the REL states and SYNC.

## Timing
- Reset values: all outputs 0, state=IDLE, watchdog=0, start_q=0.
- Start accept (edge at cycle 0): busy=1 at cycle 1. SYNC→ENC_GO at the first edge where eng_done=0, so eng_go rises at cycle 2 at the earliest.
- Operand error: err_operand and fail go to 1 at cycle 1, busy stays 0, and eng_go never rises.
- eng_done=1 sampled at edge k: eng_go=0 and the result is captured at k+1.
- DEC_REL exit to CHECK takes 1 cycle; pass/fail/busy update 1 cycle after CHECK.
- Fixed overhead per run is 6 cycles plus the two engine latencies plus the done-release waits.
- Abort sampled at edge k: eng_go=0 and state=IDLE at k+1.
- Reset asserted mid-run: eng_go drops asynchronously and everything returns to reset values.

## Test plan
- n=3233, e=17, d=2753, m=65, with a behavioural engine at 20-cycle latency → cipher=2790, plain=65, pass=1, fail=0, and eng_go rose exactly twice.
- Same run with d=2752 → cipher=2790, plain≠65, fail=1, pass=0.
- modulus=3232 (even), then msg=4000 with n=3233 → err_operand=1 and fail=1 one cycle after start, eng_go stays 0 throughout.
- Engine that never asserts done, TIMEOUT_CYCLES=16 → eng_go falls and timeout=1 16 cycles after ENC_GO entry, busy=0.
- abort pulse during DEC_GO → eng_go=0 next cycle, state=0, flags all 0, cipher retains 2790. A start edge during busy is ignored.
- eng_done stuck high at start for 5 cycles → state holds SYNC, eng_go stays 0 until done falls. Async reset mid-ENC_GO → all outputs 0 immediately.
